// File: rtl/inst_word_packer_pkg.sv
// Shared definitions for the instruction word packer.
//   - word geometry constants (instruction width, bytes per word, lane index width)
//   - packer FSM state type, also exported on the debug port
//   - helpers to place a byte into a lane and to build a one-hot lane mask
package inst_word_packer_pkg;

  localparam int INST_W         = 32;
  localparam int BYTES_PER_INST = 4;
  localparam int LANE_W         = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2
  } pack_state_t;

  // Replace byte lane 'lane' of 'word' with 'b'.
  function automatic logic [INST_W-1:0] put_lane(input logic [INST_W-1:0] word,
                                                 input logic [LANE_W-1:0] lane,
                                                 input logic [7:0]        b);
    logic [INST_W-1:0] w;
    w = word;
    w[8*lane +: 8] = b;
    return w;
  endfunction

  function automatic logic [BYTES_PER_INST-1:0] lane_bit(input logic [LANE_W-1:0] lane);
    logic [BYTES_PER_INST-1:0] m;
    m = '0;
    m[lane] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/inst_word_packer_if.sv
// Word write port from the packer into the instruction memory.
//   mem_wr_valid  packer -> memory  write request
//   mem_wr_ready  memory -> packer  write accepted
//   mem_wr_addr   packer -> memory  word address
//   mem_wr_data   packer -> memory  packed word, lane n at [8n+7:8n]
//   mem_wr_be     packer -> memory  byte enables (lane mask)
// Handshake: a transfer happens on a rising clk edge where mem_wr_valid and
// mem_wr_ready are both high. Once valid is raised, valid/addr/data/be hold
// steady until that edge. Ready may change freely and does not depend on valid.
interface inst_word_packer_if #(parameter int WADDR_W = 5);
  logic               mem_wr_valid;
  logic               mem_wr_ready;
  logic [WADDR_W-1:0] mem_wr_addr;
  logic [31:0]        mem_wr_data;
  logic [3:0]         mem_wr_be;

  modport master(output mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_be,
                 input  mem_wr_ready);
  modport slave (input  mem_wr_valid, mem_wr_addr, mem_wr_data, mem_wr_be,
                 output mem_wr_ready);
endinterface

// File: rtl/inst_word_packer_sync.sv
// sync_rise_detect: brings an asynchronous level into the clk domain through
// SYNC_STAGES flops and emits a one-cycle pulse on each rising edge of the
// synchronised level.
//   clk, rst_n   clock, async active-low reset (all flops to 0)
//   async_in     asynchronous level
//   rise_pulse   high for one cycle per synchronised rising edge
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/inst_word_packer.sv
// inst_word_packer: collects host byte writes into 32-bit instruction words
// and issues one word write per word to the instruction memory.
//   clk, rst_n    core clock, async active-low reset
//   pin_we        host byte strobe (asynchronous), one capture per rising edge
//   pin_addr      byte address: [1:0] lane, upper bits word address
//   pin_data      byte data
//   mem           word write port (master side)
//   busy          a partial word, pending write or held byte exists
//   overrun_err   sticky, a byte was dropped because the hold register was full
//   dbg_state     current FSM state
module inst_word_packer
  import inst_word_packer_pkg::*;
#(
  parameter int BYTE_ADDR_W = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pin_we,
  input  logic [BYTE_ADDR_W-1:0] pin_addr,
  input  logic [7:0]             pin_data,
  inst_word_packer_if.master     mem,
  output logic                   busy,
  output logic                   overrun_err,
  output pack_state_t            dbg_state
);

  localparam int WADDR_W = BYTE_ADDR_W - LANE_W;

  logic                      capture;
  logic                      hs;
  logic [WADDR_W-1:0]        cap_waddr;
  logic [LANE_W-1:0]         cap_lane;
  logic [BYTES_PER_INST-1:0] cap_mask;

  pack_state_t               state_q, state_d;
  logic [INST_W-1:0]         acc_q, acc_d;
  logic [BYTES_PER_INST-1:0] mask_q, mask_d;
  logic [WADDR_W-1:0]        waddr_q, waddr_d;
  logic                      hold_valid_q, hold_valid_d;
  logic [LANE_W-1:0]         hold_lane_q, hold_lane_d;
  logic [WADDR_W-1:0]        hold_waddr_q, hold_waddr_d;
  logic [7:0]                hold_data_q, hold_data_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;

  // pin_addr/pin_data are held stable by the host across the synchroniser
  // delay, so they are sampled directly on the capture cycle.
  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (pin_we),
    .rise_pulse (capture)
  );

  assign cap_waddr = pin_addr[BYTE_ADDR_W-1:LANE_W];
  assign cap_lane  = pin_addr[LANE_W-1:0];
  assign cap_mask  = lane_bit(cap_lane);
  assign hs        = valid_q & mem.mem_wr_ready;

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mask_d       = mask_q;
    waddr_d      = waddr_q;
    hold_valid_d = hold_valid_q;
    hold_lane_d  = hold_lane_q;
    hold_waddr_d = hold_waddr_q;
    hold_data_d  = hold_data_q;
    overrun_d    = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          acc_d   = put_lane('0, cap_lane, pin_data);
          mask_d  = cap_mask;
          waddr_d = cap_waddr;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (capture) begin
          if (cap_waddr == waddr_q) begin
            acc_d  = put_lane(acc_q, cap_lane, pin_data);
            mask_d = mask_q | cap_mask;
            if (&(mask_q | cap_mask)) state_d = ST_WRITE;
          end else begin
            // Byte for another word: flush the partial, park the new byte.
            hold_valid_d = 1'b1;
            hold_lane_d  = cap_lane;
            hold_waddr_d = cap_waddr;
            hold_data_d  = pin_data;
            state_d      = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (hs) begin
          if (hold_valid_q) begin
            acc_d        = put_lane('0, hold_lane_q, hold_data_q);
            mask_d       = lane_bit(hold_lane_q);
            waddr_d      = hold_waddr_q;
            hold_valid_d = 1'b0;
            state_d      = ST_COLLECT;
            // The hold register was still full on this cycle.
            if (capture) overrun_d = 1'b1;
          end else if (capture) begin
            // Byte lands in the empty hold slot and is consumed at once.
            acc_d   = put_lane('0, cap_lane, pin_data);
            mask_d  = cap_mask;
            waddr_d = cap_waddr;
            state_d = ST_COLLECT;
          end else begin
            acc_d   = '0;
            mask_d  = '0;
            state_d = ST_IDLE;
          end
        end else if (capture) begin
          if (hold_valid_q) begin
            overrun_d = 1'b1;
          end else begin
            hold_valid_d = 1'b1;
            hold_lane_d  = cap_lane;
            hold_waddr_d = cap_waddr;
            hold_data_d  = pin_data;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    valid_d = (state_d == ST_WRITE);
    busy_d  = (state_d != ST_IDLE) | hold_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      mask_q       <= '0;
      waddr_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_lane_q  <= '0;
      hold_waddr_q <= '0;
      hold_data_q  <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mask_q       <= mask_d;
      waddr_q      <= waddr_d;
      hold_valid_q <= hold_valid_d;
      hold_lane_q  <= hold_lane_d;
      hold_waddr_q <= hold_waddr_d;
      hold_data_q  <= hold_data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign mem.mem_wr_valid = valid_q;
  assign mem.mem_wr_addr  = waddr_q;
  assign mem.mem_wr_data  = acc_q;
  assign mem.mem_wr_be    = mask_q;
  assign busy             = busy_q;
  assign overrun_err      = overrun_q;
  assign dbg_state        = state_q;

endmodule
